// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial add/subtract controller.
package serial_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit-counter width: enough to index WIDTH bits, at least one bit.
  function automatic int cnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full-adder cell, the single arithmetic element of the serial adder.
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder/subtractor: one full-adder cell reused over WIDTH clocks,
// LSB first, with the carry held in a flop between bits.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int               CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] r_nxt;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             last;
  logic             fa_sum;
  logic             fa_carry;
  logic             unused_r_lsb;

  assign last = (cnt == CNT_LAST);

  fa u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .carry(fa_carry)
  );

  // Result shift register: new bit enters at the MSB; the LSB falls off.
  if (WIDTH == 1) begin : g_r_one
    assign r_nxt = fa_sum;
  end else begin : g_r_many
    assign r_nxt = {fa_sum, r_sr[WIDTH-1:1]};
  end

  assign unused_r_lsb = r_sr[0];

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: accept in IDLE, run WIDTH bits, one DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN:   if (last)  state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Operand/result shift registers, carry flop and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      r_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // Subtract as A + ~B + 1; the +1 rides in through the carry flop.
            a_sr  <= op_a;
            b_sr  <= sub ? ~op_b : op_b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          r_sr  <= r_nxt;
          carry <= fa_carry;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Result registers, loaded on the last bit and held until the next op ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (state == S_RUN && last) begin
      sum  <= r_nxt;
      cout <= fa_carry;
      // Signed overflow: carry into the MSB differs from carry out of it.
      ovf  <= carry ^ fa_carry;
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: WIDTH=8 instance checked through a scoreboard,
// plus a WIDTH=1 instance checked directly.
module tb_serial_add_ctrl;

  typedef struct packed {
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start, sub, cin;
  logic [7:0] op_a, op_b;
  logic       busy, done, cout, ovf;
  logic [7:0] sum;

  logic       s1_start, s1_sub, s1_cin;
  logic [0:0] s1_op_a, s1_op_b, s1_sum;
  logic       s1_busy, s1_done, s1_cout, s1_ovf;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  exp_t sb[$];
  int   done_cycles[$];

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .op_a(op_a),
    .op_b(op_b), .cin(cin), .busy(busy), .done(done), .sum(sum),
    .cout(cout), .ovf(ovf)
  );

  serial_add_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(s1_start), .sub(s1_sub), .op_a(s1_op_a),
    .op_b(s1_op_b), .cin(s1_cin), .busy(s1_busy), .done(s1_done), .sum(s1_sum),
    .cout(s1_cout), .ovf(s1_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Golden model: returns {ovf, cout, sum[63:0]} for a w-bit operation.
  function automatic logic [65:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic s, input logic c);
    logic [64:0] mask, aa, bb, full;
    logic [63:0] sm;
    logic        co, ov;
    mask = (65'd1 << w) - 65'd1;
    aa   = {1'b0, a} & mask;
    bb   = {1'b0, (s ? ~b : b)} & mask;
    full = aa + bb + {64'd0, (s ? 1'b1 : c)};
    co   = full[w];
    sm   = full[63:0] & mask[63:0];
    ov   = (aa[w-1] == bb[w-1]) && (sm[w-1] != aa[w-1]);
    return {ov, co, sm};
  endfunction

  function automatic exp_t mk8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c);
    logic [65:0] r;
    exp_t e;
    r      = model(8, {56'd0, a}, {56'd0, b}, s, c);
    e.sum  = r[7:0];
    e.cout = r[64];
    e.ovf  = r[65];
    return e;
  endfunction

  // Scoreboard monitor on the 8-bit instance.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (done) begin
      done_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        check("spurious_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        check("sum",  64'(sum),  64'(e.sum));
        check("cout", 64'(cout), 64'(e.cout));
        check("ovf",  64'(ovf),  64'(e.ovf));
      end
    end
  end

  // One 8-bit operation with latency/busy checks; optional disturbance while busy.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s, input logic c,
                        input bit disturb);
    int n, busy_n;
    @(negedge clk);
    op_a = a; op_b = b; sub = s; cin = c; start = 1'b1;
    sb.push_back(mk8(a, b, s, c));
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    n      = 1;
    busy_n = 0;
    while (!done && n < 40) begin
      if (busy) busy_n++;
      if (disturb) begin
        start = 1'($urandom);
        op_a  = 8'($urandom);
        op_b  = 8'($urandom);
        sub   = 1'($urandom);
        cin   = 1'($urandom);
      end
      @(negedge clk);
      n++;
    end
    if (busy) busy_n++;
    start = disturb ? 1'b1 : 1'b0;
    check("latency", 64'(n), 64'd9);
    check("busy_len", 64'(busy_n), 64'd9);
    @(negedge clk);
    start = 1'b0;
    check("done_pulse", 64'({done, busy}), 64'd0);
  endtask

  task automatic run_op1(input logic a, input logic b, input logic s, input logic c);
    int n;
    logic [65:0] r;
    @(negedge clk);
    s1_op_a = a; s1_op_b = b; s1_sub = s; s1_cin = c; s1_start = 1'b1;
    r = model(1, {63'd0, a}, {63'd0, b}, s, c);
    @(posedge clk);
    @(negedge clk);
    s1_start = 1'b0;
    n = 1;
    while (!s1_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("w1_latency", 64'(n), 64'd2);
    check("w1_sum",  64'(s1_sum),  64'(r[0]));
    check("w1_cout", 64'(s1_cout), 64'(r[64]));
    check("w1_ovf",  64'(s1_ovf),  64'(r[65]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; op_a = '0; op_b = '0;
    s1_start = 1'b0; s1_sub = 1'b0; s1_cin = 1'b0; s1_op_a = '0; s1_op_b = '0;
    repeat (3) @(negedge clk);
    check("rst_outputs", 64'({busy, done, sum, cout, ovf}), 64'd0);
    rst_n = 1'b1;

    // Load non-zero results, then reset mid-run.
    run_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    op_a = 8'h5A; op_b = 8'h3C; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_outs", 64'({done, sum, cout, ovf}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cycles.size();
    repeat (20) @(negedge clk);
    check("no_done_after_rst", 64'(done_cycles.size() - d0), 64'd0);

    // Directed add/subtract cases.
    run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    run_op(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    run_op(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
    run_op(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);

    // Start pulses and operand changes while busy are ignored.
    run_op(8'hA5, 8'h5A, 1'b0, 1'b1, 1'b1);
    run_op(8'h33, 8'hCC, 1'b1, 1'b0, 1'b1);
    d0 = done_cycles.size();
    repeat (15) @(negedge clk);
    check("no_queued_op", 64'(done_cycles.size() - d0), 64'd0);

    // start held high: back-to-back ops every WIDTH+2 cycles.
    @(negedge clk);
    op_a = 8'h12; op_b = 8'h34; sub = 1'b0; cin = 1'b0; start = 1'b1;
    d0 = done_cycles.size();
    repeat (3) sb.push_back(mk8(8'h12, 8'h34, 1'b0, 1'b0));
    repeat (21) @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("held_done_count", 64'(done_cycles.size() - d0), 64'd3);
    if (done_cycles.size() >= d0 + 3) begin
      check("held_spacing0", 64'(done_cycles[d0+1] - done_cycles[d0]), 64'd10);
      check("held_spacing1", 64'(done_cycles[d0+2] - done_cycles[d0+1]), 64'd10);
    end

    // Random operations.
    for (int i = 0; i < 200; i++) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    // WIDTH = 1 instance: every operand combination.
    run_op1(1'b1, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      run_op1(k[0], k[1], k[2], k[3]);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
